// File: rtl/riscv_pkg.sv
// Shared RV32 encodings and LSU types: opcodes, funct3 access codes, FSM state
// and the access-size decode used by the MEM-stage load/store unit.
package riscv_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic {IDLE, BUSY} lsu_state_t;

  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_NONE} acc_size_t;

  // SZ_NONE marks an illegal funct3 for the given direction.
  function automatic acc_size_t f3_size(input logic is_load, input logic [2:0] f3);
    acc_size_t sz;
    sz = SZ_NONE;
    if (is_load) begin
      case (f3)
        F3_LB, F3_LBU: sz = SZ_BYTE;
        F3_LH, F3_LHU: sz = SZ_HALF;
        F3_LW:         sz = SZ_WORD;
        default:       sz = SZ_NONE;
      endcase
    end else begin
      case (f3)
        F3_SB:   sz = SZ_BYTE;
        F3_SH:   sz = SZ_HALF;
        F3_SW:   sz = SZ_WORD;
        default: sz = SZ_NONE;
      endcase
    end
    return sz;
  endfunction

endpackage

// File: rtl/lsu_data_ram.sv
// DEPTH x XLEN synchronous data RAM with per-byte write enables and a
// one-cycle registered read port.
module lsu_data_ram #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     re,
  input  logic [XLEN/8-1:0]        be,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [XLEN-1:0]          wdata,
  output logic [XLEN-1:0]          rdata
);

  logic [XLEN-1:0] mem [DEPTH];

  // NOTE: the storage array and read register carry no reset so the array maps onto
  // block RAM; contents survive a pipeline reset by design.
  always_ff @(posedge clk) begin
    for (int b = 0; b < XLEN/8; b++) begin
      if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// RV32 MEM-stage load/store unit: wait-state FSM, store lane steering, load
// extension and next-PC resolution. Optional macro: LSU_MISALIGN_TRAP_EN.
module lsu_mem_stage
  import riscv_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_in,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            zero,
  input  logic [XLEN-1:0] npc,
  output logic            stall,
  output logic            valid_out,
  output logic [XLEN-1:0] lmd,
  output logic [XLEN-1:0] condpc,
  output logic            pc_sel,
  output logic            misalign
);

  localparam int NB = XLEN / 8;
  localparam int OB = $clog2(NB);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WS_CNT = 4'(WAIT_STATES);

  lsu_state_t      state;
  logic [3:0]      wait_cnt;

  logic            is_load, is_store, is_mem, accept, fire;
  logic            mis_raw, mis_now, bad_f3;
  acc_size_t       size;
  logic [OB-1:0]   off;
  logic [NB-1:0]   be;
  logic [XLEN-1:0] wdata, rdata, shifted, load_val;
  logic            taken;
  logic [XLEN-1:0] target;

  // Captured at acceptance and retired when the access completes.
  logic            p_valid, p_load, p_mem, p_zero, p_mis, p_pc_sel;
  logic [2:0]      p_f3;
  logic [OB-1:0]   p_off;
  logic [XLEN-1:0] p_condpc;

  logic            unused_addr;
  assign unused_addr = ^alu_result[XLEN-1:OB+AW];

  // NOTE: every always_comb output gets a default first so no path leaves a latch.
  always_comb begin
    is_load  = (opcode == OPC_LOAD);
    is_store = (opcode == OPC_STORE);
    is_mem   = is_load || is_store;
    accept   = valid_in && (state == IDLE);
    fire     = p_valid && (state == IDLE);
    size     = f3_size(is_load, funct3);
    bad_f3   = is_mem && (size == SZ_NONE);
    off      = alu_result[OB-1:0];
    mis_raw  = ((size == SZ_HALF) && off[0]) || ((size == SZ_WORD) && (|off));
`ifdef LSU_MISALIGN_TRAP_EN
    mis_now  = is_mem && mis_raw;
`else
    mis_now  = 1'b0;
    if (size == SZ_HALF) off[0] = 1'b0;
    if (size == SZ_WORD) off    = '0;
`endif

    be    = '0;
    wdata = rs2_data;
    case (size)
      SZ_BYTE: begin be = NB'(1) << off; wdata = {NB{rs2_data[7:0]}}; end
      SZ_HALF: begin be = NB'(3) << off; wdata = {(NB/2){rs2_data[15:0]}}; end
      SZ_WORD: be = '1;
      default: be = '0;
    endcase
    if (!(accept && is_store && !mis_now)) be = '0;

    taken  = ((opcode == OPC_BRANCH) && zero) || (opcode == OPC_JAL) || (opcode == OPC_JALR);
    target = taken ? alu_result : npc;
    if (opcode == OPC_JALR) target[0] = 1'b0;
  end

  always_comb begin
    shifted = rdata >> {p_off, 3'b000};
    case (p_f3)
      F3_LB:   load_val = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      F3_LH:   load_val = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      F3_LBU:  load_val = {{(XLEN-8){1'b0}}, shifted[7:0]};
      F3_LHU:  load_val = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  lsu_data_ram #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .re    (accept && is_load),
    .be    (be),
    .addr  (alu_result[OB+AW-1:OB]),
    .wdata (wdata),
    .rdata (rdata)
  );

  assign stall = (state == BUSY);

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      p_valid   <= 1'b0;
      p_load    <= 1'b0;
      p_mem     <= 1'b0;
      p_zero    <= 1'b0;
      p_mis     <= 1'b0;
      p_pc_sel  <= 1'b0;
      p_f3      <= '0;
      p_off     <= '0;
      p_condpc  <= '0;
      valid_out <= 1'b0;
      lmd       <= '0;
      condpc    <= '0;
      pc_sel    <= 1'b0;
      misalign  <= 1'b0;
    end else begin
      valid_out <= fire;
      if (fire) begin
        condpc   <= p_condpc;
        pc_sel   <= p_pc_sel;
        misalign <= p_mis;
        if (p_mem && p_zero) lmd <= '0;
        else if (p_load)     lmd <= load_val;
        p_valid  <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (accept && is_mem && (WAIT_STATES > 0)) begin
            state    <= BUSY;
            wait_cnt <= WS_CNT;
          end
        end
        BUSY: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (accept) begin
        p_valid  <= 1'b1;
        p_load   <= is_load;
        p_mem    <= is_mem;
        p_zero   <= bad_f3 || mis_now;
        p_mis    <= mis_now;
        p_f3     <= funct3;
        p_off    <= off;
        p_condpc <= target;
        p_pc_sel <= taken;
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed scoreboard bench for lsu_mem_stage: one instance with no wait
// states, one with three, driven from a shared input bus.
module tb_lsu_mem_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid0 = 1'b0, valid1 = 1'b0;
  logic [6:0]  opcode = '0;
  logic [2:0]  funct3 = '0;
  logic [31:0] alu_result = '0, rs2_data = '0, npc = '0;
  logic        zero = 1'b0;

  logic        stall0, valid_out0, pc_sel0, misalign0;
  logic [31:0] lmd0, condpc0;
  logic        stall1, valid_out1, pc_sel1, misalign1;
  logic [31:0] lmd1, condpc1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] lmd;
    bit          chk_lmd;
    logic [31:0] condpc;
    logic        pc_sel;
    logic        mis;
    int          lat;
    int          stalls;
  } exp_t;

  exp_t sb_q[$];

  localparam logic [31:0] MEM_NPC = 32'h0000_1000;

  always #5 clk = ~clk;

  lsu_mem_stage #(.XLEN(32), .DEPTH(1024), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst(rst), .valid_in(valid0), .opcode(opcode), .funct3(funct3),
    .alu_result(alu_result), .rs2_data(rs2_data), .zero(zero), .npc(npc),
    .stall(stall0), .valid_out(valid_out0), .lmd(lmd0), .condpc(condpc0),
    .pc_sel(pc_sel0), .misalign(misalign0)
  );

  lsu_mem_stage #(.XLEN(32), .DEPTH(1024), .WAIT_STATES(3)) u_dut1 (
    .clk(clk), .rst(rst), .valid_in(valid1), .opcode(opcode), .funct3(funct3),
    .alu_result(alu_result), .rs2_data(rs2_data), .zero(zero), .npc(npc),
    .stall(stall1), .valid_out(valid_out1), .lmd(lmd1), .condpc(condpc1),
    .pc_sel(pc_sel1), .misalign(misalign1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] l, input bit chk, input logic [31:0] pc,
                              input logic sel, input logic m, input int lat, input int st);
    exp_t e;
    e.lmd = l; e.chk_lmd = chk; e.condpc = pc; e.pc_sel = sel;
    e.mis = m; e.lat = lat; e.stalls = st;
    return e;
  endfunction

  // Issues one instruction; for 'hold' cycles after acceptance valid_in stays
  // high carrying a JAL that a stalled unit must ignore.
  task automatic do_op(input bit sel, input string tag, input logic [6:0] op,
                       input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data,
                       input logic z, input logic [31:0] np, input exp_t e, input int hold);
    exp_t        got_e;
    bit          found;
    int          lat, stalls, extra;
    logic        vo, st, ps, ms;
    logic [31:0] l, pc;
    sb_q.push_back(e);
    @(negedge clk);
    opcode = op; funct3 = f3; alu_result = addr; rs2_data = data; zero = z; npc = np;
    if (sel) valid1 = 1'b1; else valid0 = 1'b1;
    @(negedge clk);
    found = 1'b0; lat = -1; stalls = 0;
    l = '0; pc = '0; ps = 1'b0; ms = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (k > 0) @(negedge clk);
      if (k == hold) begin
        valid0 = 1'b0; valid1 = 1'b0;
      end else if (k == 0) begin
        opcode = OPC_JAL; alu_result = 32'h0000_0BAD;
      end
      vo = sel ? valid_out1 : valid_out0;
      st = sel ? stall1 : stall0;
      if (vo) begin
        found = 1'b1; lat = k;
        l  = sel ? lmd1 : lmd0;
        pc = sel ? condpc1 : condpc0;
        ps = sel ? pc_sel1 : pc_sel0;
        ms = sel ? misalign1 : misalign0;
      end else if (st) begin
        stalls++;
      end
    end
    valid0 = 1'b0; valid1 = 1'b0;
    got_e = sb_q.pop_front();
    check({tag, " seen"}, 32'(found), 32'd1);
    if (found) begin
      check({tag, " latency"}, 32'(lat), 32'(got_e.lat));
      check({tag, " stalls"}, 32'(stalls), 32'(got_e.stalls));
      if (got_e.chk_lmd) check({tag, " lmd"}, l, got_e.lmd);
      check({tag, " condpc"}, pc, got_e.condpc);
      check({tag, " pc_sel"}, 32'(ps), 32'(got_e.pc_sel));
      check({tag, " misalign"}, 32'(ms), 32'(got_e.mis));
      extra = 0;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        if (sel ? valid_out1 : valid_out0) extra++;
      end
      check({tag, " extra pulses"}, 32'(extra), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;

    // Reset held two cycles with valid_in asserted on both units.
    valid0 = 1'b1; valid1 = 1'b1; opcode = OPC_JAL; alu_result = 32'h0000_0040; npc = 32'h0000_0044;
    @(posedge clk); @(posedge clk); @(negedge clk);
    check("rst valid_out0", 32'(valid_out0), 32'd0);
    check("rst lmd0", lmd0, 32'd0);
    check("rst condpc0", condpc0, 32'd0);
    check("rst pc_sel0", 32'(pc_sel0), 32'd0);
    check("rst misalign0", 32'(misalign0), 32'd0);
    check("rst stall0", 32'(stall0), 32'd0);
    check("rst stall1", 32'(stall1), 32'd0);
    check("rst valid_out1", 32'(valid_out1), 32'd0);
    valid0 = 1'b0; valid1 = 1'b0; rst = 1'b0;

    // Zero wait states.
    do_op(0, "SW 0x4", OPC_STORE, F3_SW, 32'h4, 32'hABCD_1234, 0, MEM_NPC, mk(0, 0, MEM_NPC, 0, 0, 1, 0), 0);
    do_op(0, "LW 0x4", OPC_LOAD,  F3_LW, 32'h4, 32'h0, 0, MEM_NPC, mk(32'hABCD_1234, 1, MEM_NPC, 0, 0, 1, 0), 0);
    do_op(0, "SW 0x8", OPC_STORE, F3_SW, 32'h8, 32'h8765_4321, 0, MEM_NPC, mk(0, 0, MEM_NPC, 0, 0, 1, 0), 0);
    do_op(0, "SB 0x9", OPC_STORE, F3_SB, 32'h9, 32'h1234_5680, 0, MEM_NPC, mk(0, 0, MEM_NPC, 0, 0, 1, 0), 0);
    do_op(0, "LB 0x9",  OPC_LOAD, F3_LB,  32'h9, 0, 0, MEM_NPC, mk(32'hFFFF_FF80, 1, MEM_NPC, 0, 0, 1, 0), 0);
    do_op(0, "LBU 0x9", OPC_LOAD, F3_LBU, 32'h9, 0, 0, MEM_NPC, mk(32'h0000_0080, 1, MEM_NPC, 0, 0, 1, 0), 0);
    do_op(0, "LW 0x8",  OPC_LOAD, F3_LW,  32'h8, 0, 0, MEM_NPC, mk(32'h8765_8021, 1, MEM_NPC, 0, 0, 1, 0), 0);
    do_op(0, "LH 0xA",  OPC_LOAD, F3_LH,  32'hA, 0, 0, MEM_NPC, mk(32'hFFFF_8765, 1, MEM_NPC, 0, 0, 1, 0), 0);
    do_op(0, "LHU 0xA", OPC_LOAD, F3_LHU, 32'hA, 0, 0, MEM_NPC, mk(32'h0000_8765, 1, MEM_NPC, 0, 0, 1, 0), 0);
    do_op(0, "LOAD f3=3", OPC_LOAD, 3'b011, 32'h8, 0, 0, MEM_NPC, mk(32'h0, 1, MEM_NPC, 0, 0, 1, 0), 0);
    do_op(0, "STORE f3=3", OPC_STORE, 3'b011, 32'h8, 32'hFFFF_FFFF, 0, MEM_NPC, mk(0, 0, MEM_NPC, 0, 0, 1, 0), 0);
    do_op(0, "LW 0x8 after bad store", OPC_LOAD, F3_LW, 32'h8, 0, 0, MEM_NPC, mk(32'h8765_8021, 1, MEM_NPC, 0, 0, 1, 0), 0);

    // PC resolution; lmd must hold the last loaded value.
    do_op(0, "BEQ taken", OPC_BRANCH, 3'b000, 32'h100, 0, 1, 32'h200, mk(32'h8765_8021, 1, 32'h100, 1, 0, 1, 0), 0);
    do_op(0, "BEQ not taken", OPC_BRANCH, 3'b000, 32'h100, 0, 0, 32'h200, mk(0, 0, 32'h200, 0, 0, 1, 0), 0);
    do_op(0, "JALR 0x301", OPC_JALR, 3'b000, 32'h301, 0, 0, 32'h200, mk(0, 0, 32'h300, 1, 0, 1, 0), 0);
    do_op(0, "JAL 0x444", OPC_JAL, 3'b000, 32'h444, 0, 0, 32'h200, mk(0, 0, 32'h444, 1, 0, 1, 0), 0);
    do_op(0, "ALU op", 7'b0110011, 3'b000, 32'h55, 0, 1, 32'h204, mk(32'h8765_8021, 1, 32'h204, 0, 0, 1, 0), 0);

`ifdef LSU_MISALIGN_TRAP_EN
    do_op(0, "SH 0x6", OPC_STORE, F3_SH, 32'h6, 32'h0000_BEEF, 0, MEM_NPC, mk(0, 0, MEM_NPC, 0, 0, 1, 0), 0);
    do_op(0, "SW 0x6 trap", OPC_STORE, F3_SW, 32'h6, 32'hDEAD_DEAD, 0, MEM_NPC, mk(32'h0, 1, MEM_NPC, 0, 1, 1, 0), 0);
    do_op(0, "LW 0x4 after trap", OPC_LOAD, F3_LW, 32'h4, 0, 0, MEM_NPC, mk(32'hBEEF_1234, 1, MEM_NPC, 0, 0, 1, 0), 0);
    do_op(0, "LH 0x7 trap", OPC_LOAD, F3_LH, 32'h7, 0, 0, MEM_NPC, mk(32'h0, 1, MEM_NPC, 0, 1, 1, 0), 0);
`else
    do_op(0, "LW 0x6 aligned", OPC_LOAD, F3_LW, 32'h6, 0, 0, MEM_NPC, mk(32'hABCD_1234, 1, MEM_NPC, 0, 0, 1, 0), 0);
    do_op(0, "LH 0x7 aligned", OPC_LOAD, F3_LH, 32'h7, 0, 0, MEM_NPC, mk(32'hFFFF_ABCD, 1, MEM_NPC, 0, 0, 1, 0), 0);
    do_op(0, "SW 0x6 aligned", OPC_STORE, F3_SW, 32'h6, 32'hCAFE_F00D, 0, MEM_NPC, mk(0, 0, MEM_NPC, 0, 0, 1, 0), 0);
    do_op(0, "LW 0x4 after SW 0x6", OPC_LOAD, F3_LW, 32'h4, 0, 0, MEM_NPC, mk(32'hCAFE_F00D, 1, MEM_NPC, 0, 0, 1, 0), 0);
`endif

    // Address bits above the word index wrap modulo DEPTH.
    do_op(0, "SW wrap 0x1004", OPC_STORE, F3_SW, 32'h1004, 32'h0F0F_0F0F, 0, MEM_NPC, mk(0, 0, MEM_NPC, 0, 0, 1, 0), 0);
    do_op(0, "LW 0x4 after wrap", OPC_LOAD, F3_LW, 32'h4, 0, 0, MEM_NPC, mk(32'h0F0F_0F0F, 1, MEM_NPC, 0, 0, 1, 0), 0);

    // Three wait states.
    do_op(1, "WS3 SW 0x4", OPC_STORE, F3_SW, 32'h4, 32'hABCD_1234, 0, MEM_NPC, mk(0, 0, MEM_NPC, 0, 0, 4, 3), 0);
    do_op(1, "WS3 LW 0x4 held valid", OPC_LOAD, F3_LW, 32'h4, 0, 0, MEM_NPC, mk(32'hABCD_1234, 1, MEM_NPC, 0, 0, 4, 3), 3);
    do_op(1, "WS3 JAL", OPC_JAL, 3'b000, 32'h80, 0, 0, 32'h84, mk(32'hABCD_1234, 1, 32'h80, 1, 0, 1, 0), 0);

    // Reset during BUSY: abort without a pulse, store already committed.
    @(negedge clk);
    opcode = OPC_STORE; funct3 = F3_SW; alu_result = 32'h10; rs2_data = 32'h5A5A_5A5A; npc = MEM_NPC;
    valid1 = 1'b1;
    @(negedge clk);
    valid1 = 1'b0;
    check("busy before reset", 32'(stall1), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("stall after reset", 32'(stall1), 32'd0);
    check("valid_out after reset", 32'(valid_out1), 32'd0);
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (valid_out1) pulses++;
    end
    check("pulses after abort", 32'(pulses), 32'd0);
    do_op(1, "WS3 LW 0x10 post-abort", OPC_LOAD, F3_LW, 32'h10, 0, 0, MEM_NPC, mk(32'h5A5A_5A5A, 1, MEM_NPC, 0, 0, 4, 3), 0);

    check("scoreboard empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
